seg_scan_driver: RTL and testbench

Parametrised multiplexed seven-segment display driver. It scans DIGITS 4-bit digits onto a common-anode display using an internal prescaler, so no external scan clock is needed. Each digit slot starts with a programmable dead-time to suppress ghosting. Input data is snapshotted once per frame so each frame shows a coherent value. It sits between the datapath's packed digit register and the board's AN/segment pins, and supersedes the fixed 4-digit decoder.

---
 rtl/seg_scan_driver.sv | 165 ++++++++++++++++
 tb/tb_seg_scan_driver.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// seg_scan_driver
// Multiplexed common-anode seven-segment driver. An internal prescaler steps
// through DIGITS digit slots. Each slot begins with DEAD cycles of all-dark
// output to suppress ghosting. The digit data is snapshotted once per frame.
// All outputs are registered and lag the scan state by one cycle.
// Optional feature: define SEGSCAN_LZB_EN to build leading-zero blanking.
module seg_scan_driver #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000,
    parameter int DEAD     = 2
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic [4*DIGITS-1:0]   inData,
    input  logic [DIGITS-1:0]     dpIn,
    input  logic                  hexMode,
    input  logic                  enable,
    output logic [DIGITS-1:0]     AN,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  frameTick
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx;
    logic [4*DIGITS-1:0]   shadow;
    logic [DIGITS-1:0]     shadowDp;

    logic                  slotEnd;
    logic                  frameEnd;
    logic                  inDead;
    logic [3:0]            curNib;
    logic                  curDp;
    logic                  curBlank;
    logic [DIGITS-1:0]     anSel;
    logic [6:0]            curSeg;

`ifdef SEGSCAN_LZB_EN
    logic [DIGITS-1:0]     blankMask;
    logic [DIGITS-1:0]     nextMask;
    logic                  upperZero;
`endif

    // Active-low a..g patterns; letters only appear in hex mode
    function automatic logic [6:0] decodeNibble(input logic [3:0] v, input logic hex);
        logic [6:0] s;
        s = 7'h7F;
        case (v)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = hex ? 7'b0001000 : 7'h7F;
            4'hB: s = hex ? 7'b1100000 : 7'h7F;
            4'hC: s = hex ? 7'b0110001 : 7'h7F;
            4'hD: s = hex ? 7'b1000010 : 7'h7F;
            4'hE: s = hex ? 7'b0110000 : 7'h7F;
            4'hF: s = hex ? 7'b0111000 : 7'h7F;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    assign slotEnd  = (cnt == CNT_W'(SCAN_DIV - 1));
    assign frameEnd = slotEnd && (idx == IDX_W'(DIGITS - 1));
    assign inDead   = (cnt < CNT_W'(DEAD));

    // Slot counter and digit index; dropping enable parks the scan at digit 0
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            cnt <= '0;
            idx <= '0;
        end else if (!enable) begin
            cnt <= '0;
            idx <= '0;
        end else if (slotEnd) begin
            cnt <= '0;
            idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Snapshot the digits at the start of each frame so a frame is coherent
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            shadow   <= '0;
            shadowDp <= '0;
        end else if (enable && cnt == '0 && idx == '0) begin
            shadow   <= inData;
            shadowDp <= dpIn;
        end
    end

`ifdef SEGSCAN_LZB_EN
    // A digit blanks when it and every digit to its left are zero, never digit 0
    always_comb begin
        upperZero = 1'b1;
        nextMask  = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            upperZero   = upperZero & (inData[4*i +: 4] == 4'h0);
            nextMask[i] = (i != 0) ? upperZero : 1'b0;
        end
    end

    // Blank mask is captured together with the frame snapshot
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            blankMask <= '0;
        end else if (enable && cnt == '0 && idx == '0) begin
            blankMask <= nextMask;
        end
    end
`endif

    // Pick the current digit's nibble, dp bit, blank bit and anode pattern
    always_comb begin
        curNib   = 4'h0;
        curDp    = 1'b0;
        curBlank = 1'b0;
        anSel    = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                curNib   = shadow[4*i +: 4];
                curDp    = shadowDp[i];
                anSel[i] = 1'b0;
`ifdef SEGSCAN_LZB_EN
                curBlank = blankMask[i];
`endif
            end
        end
        curSeg = curBlank ? 7'h7F : decodeNibble(curNib, hexMode);
    end

    // Registered pin drive: dark while disabled or in dead-time, else the digit
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            AN        <= '1;
            seg       <= 7'h7F;
            dp        <= 1'b1;
            frameTick <= 1'b0;
        end else begin
            frameTick <= enable && frameEnd;
            if (!enable || inDead) begin
                AN  <= '1;
                seg <= 7'h7F;
                dp  <= 1'b1;
            end else begin
                AN  <= anSel;
                seg <= curSeg;
                dp  <= ~curDp;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver
// Bench for seg_scan_driver with DIGITS=4, SCAN_DIV=4, DEAD=1. A frame-position
// reference model predicts every output cycle. Build with SEGSCAN_LZB_EN
// defined to predict leading-zero blanking as well.
module tb_seg_scan_driver;

    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 4;
    localparam int DEAD     = 1;
    localparam int FRAME    = DIGITS * SCAN_DIV;

    logic        clk;
    logic        rstN;
    logic [15:0] inData;
    logic [3:0]  dpIn;
    logic        hexMode;
    logic        enable;
    logic [3:0]  AN;
    logic [6:0]  seg;
    logic        dp;
    logic        frameTick;

    int checks = 0;
    int errors = 0;

    // Reference model state: position within frame and the frame snapshot
    int          pos;
    logic [15:0] snap;
    logic [3:0]  snapDp;
    logic [12:0] expOut;

    logic [6:0] segTab [16];

    seg_scan_driver #(
        .DIGITS(DIGITS),
        .SCAN_DIV(SCAN_DIV),
        .DEAD(DEAD)
    ) dut (
        .clk(clk),
        .rstN(rstN),
        .inData(inData),
        .dpIn(dpIn),
        .hexMode(hexMode),
        .enable(enable),
        .AN(AN),
        .seg(seg),
        .dp(dp),
        .frameTick(frameTick)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clear the model to its post-reset state
    task automatic modelReset();
        pos    = 0;
        snap   = 16'h0000;
        snapDp = 4'h0;
    endtask

    // Predict the outputs for this edge, clock once, then advance the model
    task automatic applyStimulus();
        int          slot;
        int          off;
        logic [15:0] sh;
        logic [6:0]  s;
        logic [3:0]  an;
        logic        d;
        logic        tick;
        logic        en;
        logic [15:0] din;
        logic [3:0]  ddp;
        slot = pos / SCAN_DIV;
        off  = pos % SCAN_DIV;
        en   = enable;
        din  = inData;
        ddp  = dpIn;
        tick = en && (pos == FRAME - 1);
        if (!en || off < DEAD) begin
            an = 4'hF;
            s  = 7'h7F;
            d  = 1'b1;
        end else begin
            sh = snap >> (4 * slot);
            s  = segTab[sh[3:0]];
            if (sh[3:0] >= 4'd10 && !hexMode) s = 7'h7F;
`ifdef SEGSCAN_LZB_EN
            if (slot > 0 && sh == 16'h0000) s = 7'h7F;
`endif
            an = 4'hF & ~(4'h1 << slot);
            d  = ~snapDp[slot];
        end
        expOut = {an, s, d, tick};
        @(posedge clk);
        #1;
        if (en && pos == 0) begin
            snap   = din;
            snapDp = ddp;
        end
        pos = en ? (pos + 1) % FRAME : 0;
    endtask

    // Synchronous-looking reset pulse used between scenarios
    task automatic doReset();
        @(negedge clk);
        rstN   = 1'b0;
        enable = 1'b0;
        @(posedge clk);
        #1;
        modelReset();
        rstN = 1'b1;
    endtask

    task automatic test_reset();
        rstN    = 1'b0;
        enable  = 1'b1;
        inData  = 16'h1234;
        dpIn    = 4'hF;
        hexMode = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (AN !== 4'hF) begin
            errors++;
            $display("[TB] FAIL reset_AN got %b exp %b", AN, 4'hF);
        end
        checks++;
        if (seg !== 7'h7F) begin
            errors++;
            $display("[TB] FAIL reset_seg got %b exp %b", seg, 7'h7F);
        end
        checks++;
        if (dp !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_dp got %b exp 1", dp);
        end
        checks++;
        if (frameTick !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_tick got %b exp 0", frameTick);
        end
        enable = 1'b0;
        modelReset();
        rstN = 1'b1;
    endtask

    task automatic test_scan();
        int ticks;
        ticks   = 0;
        inData  = 16'h1234;
        dpIn    = 4'b0100;
        hexMode = 1'b0;
        enable  = 1'b1;
        for (int c = 0; c < 2 * FRAME; c++) begin
            applyStimulus();
            if (frameTick === 1'b1) ticks++;
            checks++;
            if ({AN, seg, dp, frameTick} !== expOut) begin
                errors++;
                $display("[TB] FAIL scan cyc %0d got AN=%b seg=%b dp=%b tick=%b exp %b_%b_%b_%b",
                         c, AN, seg, dp, frameTick, expOut[12:9], expOut[8:2], expOut[1], expOut[0]);
            end
        end
        checks++;
        if (ticks != 2) begin
            errors++;
            $display("[TB] FAIL scan_tick_count got %0d exp 2", ticks);
        end
    endtask

    task automatic test_coherency();
        doReset();
        inData = 16'h1234;
        dpIn   = 4'b0000;
        enable = 1'b1;
        for (int c = 0; c < 2 * FRAME && pos != 2 * SCAN_DIV + 1; c++) applyStimulus();
        inData = 16'h5678;
        for (int c = 0; c < 2 * FRAME; c++) begin
            applyStimulus();
            checks++;
            if ({AN, seg, dp, frameTick} !== expOut) begin
                errors++;
                $display("[TB] FAIL coherency cyc %0d got AN=%b seg=%b dp=%b tick=%b exp %b_%b_%b_%b",
                         c, AN, seg, dp, frameTick, expOut[12:9], expOut[8:2], expOut[1], expOut[0]);
            end
        end
    endtask

    task automatic test_hexmode();
        doReset();
        inData = 16'hABCD;
        dpIn   = 4'b1001;
        enable = 1'b1;
        for (int c = 0; c < 2 * FRAME; c++) begin
            hexMode = (c < FRAME);
            applyStimulus();
            checks++;
            if ({AN, seg, dp, frameTick} !== expOut) begin
                errors++;
                $display("[TB] FAIL hexmode cyc %0d got AN=%b seg=%b dp=%b tick=%b exp %b_%b_%b_%b",
                         c, AN, seg, dp, frameTick, expOut[12:9], expOut[8:2], expOut[1], expOut[0]);
            end
        end
    endtask

    task automatic test_enable();
        doReset();
        inData  = 16'h9087;
        dpIn    = 4'b0011;
        hexMode = 1'b1;
        enable  = 1'b1;
        for (int c = 0; c < FRAME && pos != 6; c++) applyStimulus();
        enable = 1'b0;
        applyStimulus();
        checks++;
        if (AN !== 4'hF || frameTick !== 1'b0) begin
            errors++;
            $display("[TB] FAIL enable_drop got AN=%b tick=%b exp 1111 0", AN, frameTick);
        end
        inData = 16'h4321;
        for (int c = 0; c < 3; c++) applyStimulus();
        enable = 1'b1;
        for (int c = 0; c < FRAME + 10; c++) begin
            if (pos == FRAME - 1 && c > FRAME) enable = 1'b0;
            applyStimulus();
            checks++;
            if ({AN, seg, dp, frameTick} !== expOut) begin
                errors++;
                $display("[TB] FAIL enable cyc %0d got AN=%b seg=%b dp=%b tick=%b exp %b_%b_%b_%b",
                         c, AN, seg, dp, frameTick, expOut[12:9], expOut[8:2], expOut[1], expOut[0]);
            end
        end
    endtask

    task automatic test_async_reset();
        doReset();
        inData  = 16'h8888;
        dpIn    = 4'hF;
        enable  = 1'b1;
        for (int c = 0; c < 2 * FRAME && pos != 7; c++) applyStimulus();
        #2;
        rstN = 1'b0;
        #1;
        checks++;
        if ({AN, seg, dp, frameTick} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL async_reset got AN=%b seg=%b dp=%b tick=%b exp 1111_1111111_1_0",
                     AN, seg, dp, frameTick);
        end
        modelReset();
        rstN   = 1'b1;
        inData = 16'h2580;
        for (int c = 0; c < FRAME + 4; c++) begin
            applyStimulus();
            checks++;
            if ({AN, seg, dp, frameTick} !== expOut) begin
                errors++;
                $display("[TB] FAIL after_reset cyc %0d got AN=%b seg=%b dp=%b tick=%b exp %b_%b_%b_%b",
                         c, AN, seg, dp, frameTick, expOut[12:9], expOut[8:2], expOut[1], expOut[0]);
            end
        end
    endtask

    task automatic test_lzb();
        doReset();
        inData  = 16'h0040;
        dpIn    = 4'b1000;
        hexMode = 1'b0;
        enable  = 1'b1;
        for (int c = 0; c < 3 * FRAME; c++) begin
            if (c == FRAME + 3) inData = 16'h0000;
            applyStimulus();
            checks++;
            if ({AN, seg, dp, frameTick} !== expOut) begin
                errors++;
                $display("[TB] FAIL lzb cyc %0d got AN=%b seg=%b dp=%b tick=%b exp %b_%b_%b_%b",
                         c, AN, seg, dp, frameTick, expOut[12:9], expOut[8:2], expOut[1], expOut[0]);
            end
        end
    endtask

    task automatic test_random();
        doReset();
        for (int c = 0; c < 400; c++) begin
            inData  = 16'($urandom);
            dpIn    = 4'($urandom);
            hexMode = 1'($urandom);
            enable  = ($urandom_range(0, 19) != 0);
            applyStimulus();
            checks++;
            if ({AN, seg, dp, frameTick} !== expOut) begin
                errors++;
                $display("[TB] FAIL random cyc %0d got AN=%b seg=%b dp=%b tick=%b exp %b_%b_%b_%b",
                         c, AN, seg, dp, frameTick, expOut[12:9], expOut[8:2], expOut[1], expOut[0]);
            end
        end
    endtask

    initial begin
        segTab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                   7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                   7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                   7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        rstN    = 1'b0;
        enable  = 1'b0;
        inData  = 16'h0000;
        dpIn    = 4'h0;
        hexMode = 1'b0;
        modelReset();
        test_reset();
        test_scan();
        test_coherency();
        test_hexmode();
        test_enable();
        test_async_reset();
        test_lzb();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
